// File: rtl/nrisc_pkg.sv
// Shared NRISC widths, the halt opcode and the fetch-stage state encoding.
package nrisc_pkg;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;
   localparam logic [DATA_W-1:0] HALT_OP = 8'hFF;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      VALID = 2'd1,
      HALT  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/nrisc_pc.sv
// Program counter register: load has priority over increment, and increment
// wraps modulo 2^ADDR_W.
module nrisc_pc
   import nrisc_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] pc
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)     pc <= RESET_PC;
      else if (load) pc <= target;
      else if (inc)  pc <= pc + 1'b1;
   end

endmodule

// File: rtl/nrisc_fetch.sv
// NRISC instruction fetch stage: drives the instruction memory address, captures
// the returned byte and hands it to decode over a valid/ready handshake.
module nrisc_fetch
   import nrisc_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clock,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_data,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              decode_ready,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   output logic              halted
);

   fetch_state_t      state, state_next;
   logic              capture, pc_load, pc_inc, valid_next;
   logic [ADDR_W-1:0] pc;

   nrisc_pc #(.RESET_PC(RESET_PC)) u_pc (
      .clock  (clock),
      .reset  (reset),
      .load   (pc_load),
      .inc    (pc_inc),
      .target (branch_target),
      .pc     (pc)
   );

   // The memory is addressed straight from the PC register, so the address
   // stays registered and can never disagree with pc.
   assign imem_addr = pc;
   assign halted    = (state == HALT);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= state_next;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_next = state;
      capture    = 1'b0;
      pc_load    = 1'b0;
      pc_inc     = 1'b0;
      valid_next = instr_valid;

      if (branch_taken) begin
         // Redirect squashes whatever is in the instruction register.
         pc_load    = 1'b1;
         valid_next = 1'b0;
         state_next = FETCH;
      end else begin
         unique case (state)
            FETCH: begin
               capture    = 1'b1;
               pc_inc     = 1'b1;
               valid_next = 1'b1;
               state_next = VALID;
            end
            VALID: begin
               if (decode_ready) begin
                  if (instr == HALT_OP) begin
                     valid_next = 1'b0;
                     state_next = HALT;
                  end else begin
                     capture    = 1'b1;
                     pc_inc     = 1'b1;
                     valid_next = 1'b1;
                  end
               end
            end
            HALT: valid_next = 1'b0;
            default: begin
               valid_next = 1'b0;
               state_next = FETCH;
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
      end else begin
         instr_valid <= valid_next;
         if (capture) begin
            instr    <= imem_data;
            instr_pc <= pc;
         end
      end
   end

endmodule
